// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 8:1 mux scan sequencer.
package mux_scan_pkg;

  localparam int unsigned MUX_NUM_CH = 8;
  localparam int unsigned MUX_SEL_W  = $clog2(MUX_NUM_CH);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    HOLD
  } scan_state_e;

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// Loadable settle-time up-counter; done flags the final settle cycle (cnt == DWELL-1).
module mux_scan_dwell_cnt #(
  parameter int unsigned DWELL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int unsigned     CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]   LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en)  cnt_q <= cnt_q + CW'(1);
  end

  assign done = (cnt_q == LAST);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps the 8:1 mux select, samples y per channel and hands the word out on valid/ready.
// Optional: MUX_SCAN_AUTO_RESTART_EN makes every HOLD handshake start the next scan.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int unsigned NUM_CH = MUX_NUM_CH,
  parameter int unsigned SEL_W  = MUX_SEL_W,
  parameter int unsigned DWELL  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              mux_y_i,
  output logic [SEL_W-1:0]  sel_o,
  output logic [NUM_CH-1:0] word_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

  scan_state_e       state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_CH-1:0] word_q, word_d;
  logic [NUM_CH-1:0] shadow_q, shadow_d;
  logic              valid_q, valid_d;
  logic              cnt_clr, cnt_en, cnt_done;

  mux_scan_dwell_cnt #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .done  (cnt_done)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    word_d   = word_q;
    shadow_d = shadow_q;
    valid_d  = valid_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SETTLE;
          sel_d   = '0;
          cnt_clr = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_done) state_d = SAMPLE;
        else          cnt_en  = 1'b1;
      end
      SAMPLE: begin
        shadow_d[sel_q] = mux_y_i;
        if (sel_q == LAST_SEL) begin
          // shadow_d already carries the last channel, so the word is complete this cycle
          word_d  = shadow_d;
          valid_d = 1'b1;
          state_d = HOLD;
        end else begin
          sel_d   = sel_q + SEL_W'(1);
          cnt_clr = 1'b1;
          state_d = SETTLE;
        end
      end
      HOLD: begin
        if (ready_i) begin
          valid_d = 1'b0;
`ifdef MUX_SCAN_AUTO_RESTART_EN
          state_d = SETTLE;
          sel_d   = '0;
          cnt_clr = 1'b1;
`else
          if (start_i) begin
            state_d = SETTLE;
            sel_d   = '0;
            cnt_clr = 1'b1;
          end else begin
            state_d = IDLE;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      word_q   <= '0;
      shadow_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      word_q   <= word_d;
      shadow_q <= shadow_d;
      valid_q  <= valid_d;
    end
  end

  assign sel_o   = sel_q;
  assign word_o  = word_q;
  assign valid_o = valid_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: DWELL=1 and DWELL=3 instances fed by a mux model.
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start1 = 1'b0, ready1 = 1'b1;
  logic [7:0] pat1 = 8'h00;
  logic       y1, valid1, busy1;
  logic [2:0] sel1;
  logic [7:0] word1;

  logic       start3 = 1'b0, ready3 = 1'b1;
  logic [7:0] pat3 = 8'h00;
  logic       y3, valid3, busy3;
  logic [2:0] sel3;
  logic [7:0] word3;

  int check_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  assign y1 = pat1[sel1];
  assign y3 = pat3[sel3];

  mux_scan_sequencer #(.NUM_CH(8), .SEL_W(3), .DWELL(1)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .mux_y_i(y1), .sel_o(sel1),
    .word_o(word1), .valid_o(valid1), .ready_i(ready1), .busy_o(busy1)
  );

  mux_scan_sequencer #(.NUM_CH(8), .SEL_W(3), .DWELL(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start_i(start3), .mux_y_i(y3), .sel_o(sel3),
    .word_o(word3), .valid_o(valid3), .ready_i(ready3), .busy_o(busy3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after the start-accept edge.
  task automatic start_scan1();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) begin
      start1 = ~start1;
      start3 = ~start3;
      tick();
    end
    start1 = 1'b0;
    start3 = 1'b0;
    check_cnt++; if (sel1 !== 3'd0) $display("FAIL reset_sel got %0d want 0", sel1); else pass_cnt++;
    check_cnt++; if (word1 !== 8'h00) $display("FAIL reset_word got %h want 00", word1); else pass_cnt++;
    check_cnt++; if (valid1 !== 1'b0) $display("FAIL reset_valid got %b want 0", valid1); else pass_cnt++;
    check_cnt++; if (busy1 !== 1'b0) $display("FAIL reset_busy got %b want 0", busy1); else pass_cnt++;
    check_cnt++; if (busy3 !== 1'b0) $display("FAIL reset_busy3 got %b want 0", busy3); else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_scan();
    int bad = 0;
    pat1 = 8'hA5;
    ready1 = 1'b1;
    start_scan1();
    check_cnt++; if (sel1 !== 3'd0 || busy1 !== 1'b1) $display("FAIL single_accept sel %0d busy %b want 0 1", sel1, busy1); else pass_cnt++;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (sel1 !== 3'((k < 16) ? k / 2 : 7) || valid1 !== (k == 16)) begin
        $display("FAIL single_step k=%0d sel %0d valid %b want %0d %b", k, sel1, valid1, (k < 16) ? k / 2 : 7, k == 16);
        bad++;
      end
    end
    check_cnt++; if (bad != 0) $display("FAIL single_timing got %0d bad steps want 0", bad); else pass_cnt++;
    check_cnt++; if (word1 !== 8'hA5) $display("FAIL single_word got %h want a5", word1); else pass_cnt++;
    tick();
    check_cnt++; if (valid1 !== 1'b0 || busy1 !== 1'b0) $display("FAIL single_idle valid %b busy %b want 0 0", valid1, busy1); else pass_cnt++;
    check_cnt++; if (word1 !== 8'hA5 || sel1 !== 3'd7) $display("FAIL single_retain word %h sel %0d want a5 7", word1, sel1); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int bad = 0;
    pat1 = 8'h3C;
    ready1 = 1'b0;
    start_scan1();
    repeat (16) tick();
    check_cnt++; if (valid1 !== 1'b1 || word1 !== 8'h3C) $display("FAIL bp_valid valid %b word %h want 1 3c", valid1, word1); else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      pat1 = 8'h5A ^ 8'(k);
      tick();
      if (valid1 !== 1'b1 || word1 !== 8'h3C || sel1 !== 3'd7) bad++;
    end
    check_cnt++; if (bad != 0) $display("FAIL bp_hold got %0d unstable cycles want 0", bad); else pass_cnt++;
    ready1 = 1'b1;
    tick();
    check_cnt++; if (valid1 !== 1'b0 || word1 !== 8'h3C) $display("FAIL bp_release valid %b word %h want 0 3c", valid1, word1); else pass_cnt++;
  endtask

  task automatic test_ignored_start();
    int rise = -1;
    int extra = 0;
    pat1 = 8'h5A;
    ready1 = 1'b1;
    start_scan1();
    for (int k = 1; k <= 20; k++) begin
      start1 = (k == 9);
      tick();
      if (valid1 === 1'b1 && rise < 0) rise = k;
    end
    start1 = 1'b0;
    check_cnt++; if (rise != 16) $display("FAIL ign_latency got %0d want 16", rise); else pass_cnt++;
    check_cnt++; if (word1 !== 8'h5A) $display("FAIL ign_word got %h want 5a", word1); else pass_cnt++;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (valid1 !== 1'b0 || busy1 !== 1'b0) extra++;
    end
    check_cnt++; if (extra != 0) $display("FAIL ign_no_second got %0d busy cycles want 0", extra); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    pat1 = 8'hFF;
    start_scan1();
    repeat (6) tick();
    check_cnt++; if (sel1 !== 3'd3) $display("FAIL midrst_pre sel %0d want 3", sel1); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    check_cnt++;
    if (sel1 !== 3'd0 || word1 !== 8'h00 || valid1 !== 1'b0 || busy1 !== 1'b0)
      $display("FAIL midrst_async sel %0d word %h valid %b busy %b want 0 00 0 0", sel1, word1, valid1, busy1);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    int n = 0;
    pat1 = 8'hFF;
    ready1 = 1'b1;
    start_scan1();
    repeat (15) tick();
    start1 = 1'b1;
    tick();
    pat1 = 8'h00;
    check_cnt++; if (valid1 !== 1'b1 || word1 !== 8'hFF) $display("FAIL b2b_first valid %b word %h want 1 ff", valid1, word1); else pass_cnt++;
    tick();
    start1 = 1'b0;
    check_cnt++; if (valid1 !== 1'b0 || busy1 !== 1'b1 || sel1 !== 3'd0) $display("FAIL b2b_restart valid %b busy %b sel %0d want 0 1 0", valid1, busy1, sel1); else pass_cnt++;
    while (valid1 !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check_cnt++; if (n != 16) $display("FAIL b2b_spacing got %0d want 16", n); else pass_cnt++;
    check_cnt++; if (word1 !== 8'h00) $display("FAIL b2b_second got %h want 00", word1); else pass_cnt++;
    tick();
  endtask

  task automatic test_dwell3();
    int n = 0;
    pat3 = 8'h81;
    ready3 = 1'b1;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    while (valid3 !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check_cnt++; if (n != 32) $display("FAIL d3_latency got %0d want 32", n); else pass_cnt++;
    check_cnt++; if (word3 !== 8'h81) $display("FAIL d3_word got %h want 81", word3); else pass_cnt++;
`ifdef MUX_SCAN_AUTO_RESTART_EN
    for (int r = 0; r < 2; r++) begin
      n = 0;
      tick();
      n++;
      while (valid3 !== 1'b1 && n < 200) begin
        tick();
        n++;
      end
      check_cnt++; if (n != 33 || word3 !== 8'h81) $display("FAIL d3_auto_period got %0d word %h want 33 81", n, word3); else pass_cnt++;
      check_cnt++; if (busy3 !== 1'b1) $display("FAIL d3_auto_busy got %b want 1", busy3); else pass_cnt++;
    end
`else
    tick();
    check_cnt++; if (valid3 !== 1'b0 || busy3 !== 1'b0) $display("FAIL d3_idle valid %b busy %b want 0 0", valid3, busy3); else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
`ifndef MUX_SCAN_AUTO_RESTART_EN
    test_single_scan();
    test_backpressure();
    test_ignored_start();
`endif
    test_mid_reset();
`ifndef MUX_SCAN_AUTO_RESTART_EN
    test_back_to_back();
`endif
    test_dwell3();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
